// File: rtl/updown_counter_param_if.sv
// rtl/updown_counter_param_if.sv - control/status bundle for updown_counter_param
interface updown_counter_param_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             dir;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ovf_clr;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             at_bound;
  logic             ovf_sticky;

  modport master (
    output en, dir, sat, load, load_val, ovf_clr,
    input  cnt, tc, at_bound, ovf_sticky
  );

  modport slave (
    input  en, dir, sat, load, load_val, ovf_clr,
    output cnt, tc, at_bound, ovf_sticky
  );
endinterface

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - modulo-MAX_COUNT up/down counter with load, wrap/saturate and bound pulse
// Define UDC_OVF_STICKY_EN to add the sticky ovf_sticky register cleared by ovf_clr.
module updown_counter_param #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic                   clk,
  input logic                   rst,
  updown_counter_param_if.slave bus
);
  // One extra bit keeps MAX_COUNT = 2**WIDTH-1 from aliasing to 0 on increment.
  localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_COUNT};
  localparam logic [WIDTH:0] ONE     = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             bound_evt;
  logic [WIDTH:0]   up_next, dn_next, load_ext;

  always_comb begin
    up_next   = {1'b0, cnt_q} + ONE;
    dn_next   = {1'b0, cnt_q} - ONE;
    load_ext  = {1'b0, bus.load_val};
    cnt_d     = cnt_q;
    bound_evt = 1'b0;
    if (bus.load) begin
      cnt_d = (load_ext > MAX_EXT) ? MAX_COUNT : bus.load_val;
    end else if (bus.en) begin
      if (bus.dir) begin
        if (up_next > MAX_EXT) begin
          bound_evt = 1'b1;
          cnt_d     = bus.sat ? cnt_q : '0;
        end else begin
          cnt_d = up_next[WIDTH-1:0];
        end
      end else begin
        // Borrow out of the extended subtraction means cnt was 0.
        if (dn_next[WIDTH]) begin
          bound_evt = 1'b1;
          cnt_d     = bus.sat ? cnt_q : MAX_COUNT;
        end else begin
          cnt_d = dn_next[WIDTH-1:0];
        end
      end
    end
    tc_d = bound_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RESET_VAL;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.tc       = tc_q;
  assign bus.at_bound = (bus.dir && (cnt_q == MAX_COUNT)) || (!bus.dir && (cnt_q == '0));

`ifdef UDC_OVF_STICKY_EN
  logic ovf_q, ovf_d;

  // A bound event on the same edge as ovf_clr keeps the flag set.
  always_comb begin
    ovf_d = bound_evt | (ovf_q & ~bus.ovf_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf_sticky = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = bus.ovf_clr;
  assign bus.ovf_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - scoreboard bench for updown_counter_param (WIDTH=4, MAX_COUNT=9)
module tb_updown_counter_param;
  localparam int WIDTH = 4;
  localparam int MAXC  = 9;

  typedef struct {
    int cnt;
    int tc;
    int ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   m_cnt = 0;
  int   m_ovf = 0;

  updown_counter_param_if #(.WIDTH(WIDTH)) bus ();

  updown_counter_param #(
    .WIDTH(WIDTH),
    .MAX_COUNT(4'd9),
    .RESET_VAL(4'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares the registered outputs after each edge that has a pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("cnt", int'(bus.cnt), e.cnt);
        check("tc", int'(bus.tc), e.tc);
        check("ovf_sticky", int'(bus.ovf_sticky), e.ovf);
      end
    end
  end

  // Reference: step by +/-1 in unbounded integers, then fold back into 0..MAXC.
  task automatic drive(input int ld, input int lv, input int e, input int d, input int s, input int clr);
    exp_t x;
    int   nxt;
    int   ev;
    @(negedge clk);
    bus.load     = ld[0];
    bus.load_val = lv[WIDTH-1:0];
    bus.en       = e[0];
    bus.dir      = d[0];
    bus.sat      = s[0];
    bus.ovf_clr  = clr[0];
    #1;
    check("at_bound", int'(bus.at_bound), ((m_cnt == MAXC && d != 0) || (m_cnt == 0 && d == 0)) ? 1 : 0);
    ev = 0;
    if (ld != 0) begin
      m_cnt = (lv > MAXC) ? MAXC : lv;
    end else if (e != 0) begin
      nxt = (d != 0) ? m_cnt + 1 : m_cnt - 1;
      if (nxt < 0 || nxt > MAXC) begin
        ev = 1;
        if (s == 0) m_cnt = (nxt + MAXC + 1) % (MAXC + 1);
      end else begin
        m_cnt = nxt;
      end
    end
`ifdef UDC_OVF_STICKY_EN
    if (ev != 0) m_ovf = 1;
    else if (clr != 0) m_ovf = 0;
`endif
    x.cnt = m_cnt;
    x.tc  = ev;
    x.ovf = m_ovf;
    exp_q.push_back(x);
  endtask

  // Reset raised between edges must clear outputs before the next rising edge.
  task automatic reset_mid();
    @(negedge clk);
    bus.load = 1'b0;
    bus.en   = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_cnt", int'(bus.cnt), 0);
    check("rst_tc", int'(bus.tc), 0);
    check("rst_ovf", int'(bus.ovf_sticky), 0);
    m_cnt = 0;
    m_ovf = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.dir = 1'b1; bus.sat = 1'b0; bus.load = 1'b0;
    bus.load_val = '0; bus.ovf_clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_cnt", int'(bus.cnt), 0);
    check("reset_tc", int'(bus.tc), 0);
    check("reset_ovf", int'(bus.ovf_sticky), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) drive(0, 0, 1, 1, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 0);
    drive(1, 8, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 1, 0);
    drive(1, 15, 1, 1, 0, 0);
    drive(1, 3, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 0, 0);
    reset_mid();
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 0, 0);
    drive(1, 9, 0, 1, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 1);
    drive(1, 9, 0, 1, 0, 0);
    drive(0, 0, 1, 1, 0, 1);
    drive(0, 0, 1, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_mid();
      end else begin
        drive(($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 15)),
              ($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 1 : 0);
      end
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
